// File: rtl/reg_file.sv
// reg_file -- architectural register file with rename tags for a RoB-based core.
//
// Holds 32 x 32-bit registers, plus a busy bit and a RoB tag per register.
// Issue renames a destination to a RoB entry. Commit writes the value and
// frees the rename only when the committing RoB id still owns the register.
// Clear is a mispredict flush that drops every rename. x0 reads as zero.
//
// Optional feature: define REG_BYPASS_EN to forward a matching same-cycle
// commit straight to the read ports. With the macro undefined, the read ports
// show registered state only.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global enable; when low, all state is held
//   issue_rd, issue_rob_id   rename request (issue_rd == 0 means no rename)
//   commit_rd, commit_rob_id,
//   commit_value             commit write (commit_rd == 0 means no write)
//   clear                    flush all renames
//   rs1/rs2                  source register addresses
//   val1/val2                source values
//   dep1/dep2                source is waiting on a RoB result
//   tag1/tag2                RoB id of the producer (only valid when depN = 1)

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

// One read port: combinational lookup, forced to zero for x0, with an optional
// override from the commit bypass.
module reg_file_rd_port #(
  parameter int ROB_W = 4
) (
  input  logic [31:0][31:0]      regs,
  input  logic [31:0]            busy,
  input  logic [31:0][ROB_W-1:0] tags,
  input  logic [4:0]             rs,
  input  logic                   byp,
  input  logic [31:0]            byp_val,
  output logic [31:0]            val,
  output logic                   dep,
  output logic [ROB_W-1:0]       tag
);
  always_comb begin
    val = regs[rs];
    dep = busy[rs];
    tag = tags[rs];
    if (rs == 5'd0) begin
      val = '0;
      dep = 1'b0;
      tag = '0;
    end else if (byp) begin
      // The producer is committing right now, so the value is already final.
      val = byp_val;
      dep = 1'b0;
    end
  end
endmodule

module reg_file #(
  parameter int ROB_W = `ROB_SIZE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [4:0]       issue_rd,
  input  logic [ROB_W-1:0] issue_rob_id,
  input  logic [4:0]       commit_rd,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [31:0]      commit_value,
  input  logic             clear,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic [31:0]      val1,
  output logic [31:0]      val2,
  output logic             dep1,
  output logic             dep2,
  output logic [ROB_W-1:0] tag1,
  output logic [ROB_W-1:0] tag2
);
  localparam int NUM_RD = 2;

  logic [31:0][31:0]      regs;
  logic [31:0]            busy;
  logic [31:0][ROB_W-1:0] tags;

  // Later assignments in this block override earlier ones on the same entry:
  // a flush beats the commit's busy clear, and an issue beats it too, while
  // the commit value write itself always lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
      busy <= '0;
      tags <= '0;
    end else if (rdy) begin
      if (commit_rd != 5'd0) begin
        regs[commit_rd] <= commit_value;
        // A stale commit (register renamed again since) must keep the newer rename.
        if (busy[commit_rd] && tags[commit_rd] == commit_rob_id)
          busy[commit_rd] <= 1'b0;
      end
      if (clear) begin
        busy <= '0;
        tags <= '0;
      end else if (issue_rd != 5'd0) begin
        busy[issue_rd] <= 1'b1;
        tags[issue_rd] <= issue_rob_id;
      end
    end
  end

  logic [NUM_RD-1:0][4:0]       rs_a;
  logic [NUM_RD-1:0]            byp;
  logic [NUM_RD-1:0][31:0]      val_a;
  logic [NUM_RD-1:0]            dep_a;
  logic [NUM_RD-1:0][ROB_W-1:0] tag_a;

  assign rs_a = {rs2, rs1};

  // Reads see the state before this edge's issue, which is what the decoder
  // expects since it reads sources ahead of its own rename.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
`ifdef REG_BYPASS_EN
    assign byp[p] = rdy && (commit_rd == rs_a[p]) && (rs_a[p] != 5'd0) &&
                    busy[rs_a[p]] && (tags[rs_a[p]] == commit_rob_id);
`else
    assign byp[p] = 1'b0;
`endif
    reg_file_rd_port #(.ROB_W(ROB_W)) u_rd (
      .regs    (regs),
      .busy    (busy),
      .tags    (tags),
      .rs      (rs_a[p]),
      .byp     (byp[p]),
      .byp_val (commit_value),
      .val     (val_a[p]),
      .dep     (dep_a[p]),
      .tag     (tag_a[p])
    );
  end

  assign val1 = val_a[0];
  assign val2 = val_a[1];
  assign dep1 = dep_a[0];
  assign dep2 = dep_a[1];
  assign tag1 = tag_a[0];
  assign tag2 = tag_a[1];
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized run
// against an array-based reference model of the register file.
module tb_reg_file;
  localparam int RW = 4;

  logic          clk;
  logic          rst;
  logic          rdy;
  logic [4:0]    issue_rd;
  logic [RW-1:0] issue_rob_id;
  logic [4:0]    commit_rd;
  logic [RW-1:0] commit_rob_id;
  logic [31:0]   commit_value;
  logic          clear;
  logic [4:0]    rs1, rs2;
  logic [31:0]   val1, val2;
  logic          dep1, dep2;
  logic [RW-1:0] tag1, tag2;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0]   m_reg  [32];
  logic          m_busy [32];
  logic [RW-1:0] m_tag  [32];

  reg_file #(.ROB_W(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .commit_rd(commit_rd), .commit_rob_id(commit_rob_id), .commit_value(commit_value),
    .clear(clear), .rs1(rs1), .rs2(rs2),
    .val1(val1), .val2(val2), .dep1(dep1), .dep2(dep2), .tag1(tag1), .tag2(tag2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the architectural rules for one clock edge to the model.
  function automatic void model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy) begin
      if (commit_rd != 0) begin
        m_reg[commit_rd] = commit_value;
        if (m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_id) m_busy[commit_rd] = 1'b0;
      end
      if (clear) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 1'b0; m_tag[i] = '0;
        end
      end else if (issue_rd != 0) begin
        m_busy[issue_rd] = 1'b1;
        m_tag[issue_rd]  = issue_rob_id;
      end
    end
  endfunction

  function automatic logic bypass_hit(input logic [4:0] rs);
`ifdef REG_BYPASS_EN
    return rdy && rs != 0 && commit_rd == rs && m_busy[rs] && m_tag[rs] == commit_rob_id;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_val(input logic [4:0] rs);
    if (rs == 0) return '0;
    if (bypass_hit(rs)) return commit_value;
    return m_reg[rs];
  endfunction

  function automatic logic exp_dep(input logic [4:0] rs);
    if (rs == 0 || bypass_hit(rs)) return 1'b0;
    return m_busy[rs];
  endfunction

  task automatic idle();
    rst = 0; rdy = 1; clear = 0;
    issue_rd = 0; issue_rob_id = 0;
    commit_rd = 0; commit_rob_id = 0; commit_value = 0;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc(); rst = 0;
  endtask

  task automatic test_reset();
    rdy = 0; // reset must work regardless of rdy
    rst = 1; cyc(); idle();
    rs1 = 5; rs2 = 0; #1;
    checks++;
    if (val1 !== 32'd0 || dep1 !== 1'b0 || val2 !== 32'd0 || dep2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_read: val1=%h dep1=%b val2=%h dep2=%b, want 0/0/0/0", val1, dep1, val2, dep2);
    end
  endtask

  task automatic test_issue_commit();
    do_reset();
    issue_rd = 3; issue_rob_id = 2; rs1 = 3;
    #1;
    checks++; // same-cycle issue does not show on the read port
    if (dep1 !== 1'b0) begin
      errors++; $display("FAIL issue_same_cycle_read: dep1=%b want 0", dep1);
    end
    cyc(); idle();
    #1;
    checks++;
    if (dep1 !== 1'b1 || tag1 !== 4'd2) begin
      errors++; $display("FAIL issue_rename: dep1=%b tag1=%0d want 1/2", dep1, tag1);
    end
    commit_rd = 3; commit_rob_id = 2; commit_value = 32'hDEADBEEF;
    cyc(); idle();
    #1;
    checks++;
    if (val1 !== 32'hDEADBEEF || dep1 !== 1'b0) begin
      errors++; $display("FAIL commit_value: val1=%h dep1=%b want deadbeef/0", val1, dep1);
    end
  endtask

  task automatic test_stale_commit();
    do_reset();
    issue_rd = 3; issue_rob_id = 2; cyc();
    issue_rd = 3; issue_rob_id = 4; cyc(); idle();
    commit_rd = 3; commit_rob_id = 2; commit_value = 7; cyc(); idle();
    rs2 = 3; #1;
    checks++;
    if (val2 !== 32'd7 || dep2 !== 1'b1 || tag2 !== 4'd4) begin
      errors++; $display("FAIL stale_commit: val2=%0d dep2=%b tag2=%0d want 7/1/4", val2, dep2, tag2);
    end
  endtask

  task automatic test_issue_commit_same_rd();
    do_reset();
    issue_rd = 6; issue_rob_id = 1; cyc(); idle();
    commit_rd = 6; commit_rob_id = 1; commit_value = 9;
    issue_rd = 6; issue_rob_id = 5;
    cyc(); idle();
    rs1 = 6; #1;
    checks++;
    if (val1 !== 32'd9 || dep1 !== 1'b1 || tag1 !== 4'd5) begin
      errors++; $display("FAIL issue_beats_commit: val1=%0d dep1=%b tag1=%0d want 9/1/5", val1, dep1, tag1);
    end
  endtask

  task automatic test_clear_and_hold();
    do_reset();
    issue_rd = 4; issue_rob_id = 3; cyc(); idle();
    commit_rd = 5; commit_rob_id = 0; commit_value = 32'h11; // plain write, x5 not busy
    clear = 1; issue_rd = 8; issue_rob_id = 6;
    cyc(); idle();
    rs1 = 4; rs2 = 8; #1;
    checks++;
    if (dep1 !== 1'b0 || dep2 !== 1'b0 || tag1 !== 4'd0) begin
      errors++; $display("FAIL clear_flush: dep1=%b dep2=%b tag1=%0d want 0/0/0", dep1, dep2, tag1);
    end
    rs1 = 5; #1;
    checks++;
    if (val1 !== 32'h11) begin
      errors++; $display("FAIL clear_keeps_commit: val1=%h want 11", val1);
    end
    issue_rd = 9; issue_rob_id = 2; cyc(); idle(); // x9 busy tag 2
    rdy = 0; commit_rd = 5; commit_value = 32'h99; issue_rd = 5; issue_rob_id = 7;
    rs2 = 9; #1;
    checks++; // held state still readable with rdy low
    if (dep2 !== 1'b1 || tag2 !== 4'd2) begin
      errors++; $display("FAIL hold_read: dep2=%b tag2=%0d want 1/2", dep2, tag2);
    end
    cyc(); clear = 1; cyc(); idle();
    #1;
    checks++;
    if (val1 !== 32'h11 || dep1 !== 1'b0 || dep2 !== 1'b1 || tag2 !== 4'd2) begin
      errors++;
      $display("FAIL rdy_low_hold: val1=%h dep1=%b dep2=%b tag2=%0d want 11/0/1/2", val1, dep1, dep2, tag2);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    issue_rd = 4; issue_rob_id = 3; cyc(); idle();
    commit_rd = 4; commit_rob_id = 3; commit_value = 32'h55; rs1 = 4;
    #1;
    checks++;
`ifdef REG_BYPASS_EN
    if (val1 !== 32'h55 || dep1 !== 1'b0) begin
      errors++; $display("FAIL bypass_same_cycle: val1=%h dep1=%b want 55/0", val1, dep1);
    end
`else
    if (val1 !== 32'h0 || dep1 !== 1'b1 || tag1 !== 4'd3) begin
      errors++; $display("FAIL no_bypass_same_cycle: val1=%h dep1=%b tag1=%0d want 0/1/3", val1, dep1, tag1);
    end
`endif
    cyc(); idle();
    #1;
    checks++;
    if (val1 !== 32'h55 || dep1 !== 1'b0) begin
      errors++; $display("FAIL commit_next_cycle: val1=%h dep1=%b want 55/0", val1, dep1);
    end
  endtask

  task automatic test_random();
    logic [31:0] ev;
    logic        ed;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rst          = ($urandom_range(99) < 2);
      rdy          = ($urandom_range(99) < 85);
      clear        = ($urandom_range(99) < 5);
      issue_rd     = 5'($urandom_range(7));
      issue_rob_id = RW'($urandom);
      commit_rd    = 5'($urandom_range(7));
      commit_rob_id = ($urandom_range(1) == 1) ? m_tag[commit_rd] : RW'($urandom);
      commit_value = $urandom;
      rs1          = 5'($urandom_range(7));
      rs2          = 5'($urandom_range(7));
      #1;
      ev = exp_val(rs1); ed = exp_dep(rs1);
      checks++;
      if (val1 !== ev || dep1 !== ed || (ed && tag1 !== m_tag[rs1])) begin
        errors++;
        $display("FAIL rand_port1 n=%0d rs1=%0d: val1=%h dep1=%b tag1=%0d want %h/%b/%0d",
                 n, rs1, val1, dep1, tag1, ev, ed, m_tag[rs1]);
      end
      ev = exp_val(rs2); ed = exp_dep(rs2);
      checks++;
      if (val2 !== ev || dep2 !== ed || (ed && tag2 !== m_tag[rs2])) begin
        errors++;
        $display("FAIL rand_port2 n=%0d rs2=%0d: val2=%h dep2=%b tag2=%0d want %h/%b/%0d",
                 n, rs2, val2, dep2, tag2, ev, ed, m_tag[rs2]);
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    idle(); rs1 = 0; rs2 = 0;
    test_reset();
    test_issue_commit();
    test_stale_commit();
    test_issue_commit_same_rd();
    test_clear_and_hold();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter ROB_W, default `ROB_SIZE_WIDTH, the RoB index width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port rdy, input, 1; when low, all state is held.
REQ-005 SHALL have port issue_rd, input, 5, destination of the issuing instruction; 0 means no rename.
REQ-006 SHALL have port issue_rob_id, input, ROB_W, RoB entry allocated to issue_rd.
REQ-007 SHALL have port commit_rd, input, 5, destination of the committing instruction; 0 means no commit write.
REQ-008 SHALL have port commit_rob_id, input, ROB_W, RoB entry being committed.
REQ-009 SHALL have port commit_value, input, 32, result being committed.
REQ-010 SHALL have port clear, input, 1, mispredict flush from RoB.
REQ-011 SHALL have ports rs1 and rs2, input, 5 each, decoder source register addresses.
REQ-012 SHALL have ports val1 and val2, output, 32 each, source values.
REQ-013 SHALL have ports dep1 and dep2, output, 1 each, high when the source awaits a RoB result.
REQ-014 SHALL have ports tag1 and tag2, output, ROB_W each, the RoB id producing the source; valid only when depN is high.

Function
REQ-015 SHALL hold 32 x 32-bit regs, 32 busy bits and 32 ROB_W-bit tags.
REQ-016 SHALL hardwire x0: writes and renames to index 0 are ignored; rsN=0 gives valN=0, depN=0, tagN=0.
REQ-017 Commit: on posedge with rdy and commit_rd!=0, SHALL write regs[commit_rd]<=commit_value unconditionally.
REQ-018 Commit: on the same edge, SHALL clear busy[commit_rd] only if busy[commit_rd]=1 and tag[commit_rd]==commit_rob_id; a stale commit leaves busy/tag untouched.
REQ-019 Issue: on posedge with rdy, clear=0 and issue_rd!=0, SHALL set busy[issue_rd]<=1 and tag[issue_rd]<=issue_rob_id.
REQ-020 Issue and commit to the same rd in one cycle: issue SHALL win (busy=1, new tag), while the commit value SHALL still be written.
REQ-021 Clear: on posedge with rdy and clear=1, SHALL zero all busy bits and tags, ignore issue, and still perform any commit write of REQ-017.
REQ-022 Reads SHALL be combinational with zero latency: depN=busy[rsN], tagN=tag[rsN], valN=regs[rsN], subject to REQ-016 and Configuration.
REQ-023 A same-cycle issue to rsN SHALL NOT affect that cycle's read outputs, since the decoder reads sources before its own rename.
REQ-024 With rdy low, read outputs SHALL still reflect the held state.

Reset
REQ-025 On posedge with rst=1, regardless of rdy, SHALL zero all regs, busy bits and tags; outputs then read val=0, dep=0, tag=0.
REQ-026 rst SHALL take priority over clear, issue and commit in the same cycle.

Configuration
REQ-027 Macro REG_BYPASS_EN: when defined, if rdy=1, commit_rd==rsN, rsN!=0, busy[rsN]=1 and tag[rsN]==commit_rob_id, SHALL output valN=commit_value and depN=0 in the same cycle.
REQ-028 When REG_BYPASS_EN is not defined, reads SHALL reflect only registered state, so a commit becomes visible on the cycle after the edge.

Verification
REQ-029 Reset, then read rs1=5 and rs2=0 -> val1=0, dep1=0, val2=0, dep2=0.
REQ-030 Issue rd=3, id=2; next cycle commit rd=3, id=2, value 0xDEADBEEF; next cycle read rs1=3 -> val1=0xDEADBEEF, dep1=0.
REQ-031 Issue rd=3 id=2, then issue rd=3 id=4, then commit rd=3 id=2 value 7 -> regs[3]=7, dep=1, tag=4.
REQ-032 Same-cycle commit rd=6 id=1 value 9 and issue rd=6 id=5 -> next cycle val=9, dep=1, tag=5.
REQ-033 Busy x4 tag 3, then clear=1 with issue rd=8 id=6 -> next cycle x4 and x8 read dep=0; rdy=0 with any commit -> state unchanged.
REQ-034 With REG_BYPASS_EN, x4 busy tag 3 and commit rd=4 id=3 value 0x55 with rs1=4 -> same cycle val1=0x55, dep1=0; without the macro -> dep1=1, and the bypassed value appears on the following cycle.
